// File: rtl/moore_pattern_detector.sv
// Parametrised Moore sequence detector with optional overlap and a saturating match counter.
// Optional feature: define MOORE_DET_CLR_EN to add the cnt_clr counter-clear input.
module moore_pattern_detector #(
   parameter int unsigned SYM_W = 1,
   parameter int unsigned PAT_LEN = 4,
   parameter logic [PAT_LEN*SYM_W-1:0] PATTERN = 4'b1011,
   parameter bit OVERLAP = 1'b1,
   parameter int unsigned CNT_W = 8,
   localparam int unsigned SW = $clog2(PAT_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
`ifdef MOORE_DET_CLR_EN
   input  logic             cnt_clr,
`endif
   input  logic             in_valid,
   input  logic [SYM_W-1:0] in,
   output logic             match,
   output logic [SW-1:0]    state,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam logic [SW-1:0]    S_EMPTY = '0;
   localparam logic [SW-1:0]    S_FULL  = SW'(PAT_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SW-1:0]    state_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             cnt_sat_nxt;
   logic             enter_full;
   int unsigned      k_eff;

   // Symbol idx of the pattern, idx 0 being the first symbol (MSB end).
   function automatic logic [SYM_W-1:0] pat_sym(input int unsigned idx);
      return SYM_W'(PATTERN >> ((PAT_LEN - 1 - idx) * SYM_W));
   endfunction

   // Longest pattern prefix that is a suffix of (first k pattern symbols ++ sym).
   function automatic logic [SW-1:0] next_of(input int unsigned k, input logic [SYM_W-1:0] sym);
      int unsigned best;
      logic        ok;
      best = 0;
      for (int unsigned j = 1; j <= PAT_LEN; j++) begin
         if (j <= k + 1) begin
            ok = (pat_sym(j - 1) == sym);
            for (int unsigned i = 0; i + 1 < j; i++) begin
               if (pat_sym(i) != pat_sym(k + 1 - j + i)) ok = 1'b0;
            end
            if (ok) best = j;
         end
      end
      return SW'(best);
   endfunction

   // Next-state and counter update.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = match_cnt;
      enter_full  = 1'b0;
      k_eff       = 32'(state);
      if (state == S_FULL && !OVERLAP) k_eff = 0;
      if (in_valid) begin
         state_nxt  = next_of(k_eff, in);
         enter_full = (state_nxt == S_FULL);
      end
      if (enter_full && match_cnt != CNT_MAX) cnt_nxt = match_cnt + CNT_W'(1);
`ifdef MOORE_DET_CLR_EN
      // A match landing on the clear edge is kept as the first count.
      if (cnt_clr) cnt_nxt = enter_full ? CNT_W'(1) : '0;
`endif
      cnt_sat_nxt = (cnt_nxt == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_EMPTY;
         match     <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else begin
         state     <= state_nxt;
         match     <= (state_nxt == S_FULL);
         match_cnt <= cnt_nxt;
         cnt_sat   <= cnt_sat_nxt;
      end
   end

endmodule
